// File: rtl/dmem_arbiter.sv
// Shares one synchronous-SRAM data port between NUM_TILES tiles, one access in flight at a time.
// Define DMEM_ARBITER_RR_EN for round-robin selection; otherwise lowest requesting index wins.
module dmem_arbiter #(
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_TILES-1:0]        req,
  input  logic [NUM_TILES-1:0]        we,
  input  logic [NUM_TILES*ADDR_W-1:0] addr,
  input  logic [NUM_TILES*DATA_W-1:0] wdata,
  output logic [NUM_TILES-1:0]        gnt,
  output logic [NUM_TILES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned IdxW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                resp_pend_q;

  logic                arb_found;
  logic [IdxW-1:0]     arb_idx;
  logic [IdxW:0]       cand;

  // Scan from rr_ptr_q upward with wrap; with the pointer pinned at 0 this is fixed priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_TILES; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NUM_TILES)) begin
        cand = cand - (IdxW+1)'(NUM_TILES);
      end
      if (!arb_found && req[cand[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_pend_q <= 1'b0;
      gnt         <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      gnt         <= '0;
      rvalid      <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      resp_pend_q <= 1'b0;

      // SRAM data is valid the cycle after the RESP state; win_q is still the reader here.
      if (resp_pend_q) begin
        rdata         <= mem_rdata;
        rvalid[win_q] <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (arb_found) begin
            win_q   <= arb_idx;
            we_q    <= we[arb_idx];
            addr_q  <= addr[arb_idx*ADDR_W +: ADDR_W];
            wdata_q <= wdata[arb_idx*DATA_W +: DATA_W];
`ifdef DMEM_ARBITER_RR_EN
            rr_ptr_q <= (arb_idx == IdxW'(NUM_TILES - 1)) ? '0 : arb_idx + 1'b1;
`endif
            state_q <= StIssue;
          end
        end
        StIssue: begin
          mem_en     <= 1'b1;
          mem_we     <= we_q;
          mem_addr   <= addr_q;
          mem_wdata  <= wdata_q;
          gnt[win_q] <= 1'b1;
          state_q    <= we_q ? StIdle : StResp;
        end
        StResp: begin
          resp_pend_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants/read responses with their
// cycle stamps; a monitor pops and compares them, and checks idle/hold/reset behaviour.
module tb_dmem_arbiter;

  localparam int NT = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NT-1:0]    req;
  logic [NT-1:0]    we;
  logic [NT*AW-1:0] addr;
  logic [NT*DW-1:0] wdata;
  logic [NT-1:0]    gnt;
  logic [NT-1:0]    rvalid;
  logic [DW-1:0]    rdata;
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;

  dmem_arbiter #(.NUM_TILES(NT), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle synchronous SRAM; never-written words read as C0DE0000 | addr.
  bit [DW-1:0] mem [1024];
  bit          written [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : (32'hC0DE0000 | {22'b0, mem_addr});
      end
    end
  end

  typedef struct {
    int            cyc;
    logic [NT-1:0] oh;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];

  int   errors = 0;
  int   checks = 0;
  logic done = 1'b0;
  logic mon_fin = 1'b0;
  logic [NT-1:0] hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sole owner of the counters.
  initial begin : monitor
    exp_t e;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    logic [DW-1:0] last_rdata;
    logic          rst_prev;
    last_addr  = '0;
    last_wdata = '0;
    last_rdata = '0;
    rst_prev   = 1'b1;
    forever begin
      @(negedge clk or negedge rst);
      if (done) begin
        chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
        chk("rvalid_queue_empty", 32'(rq.size()), 32'd0);
        mon_fin = 1'b1;
        break;
      end
      if (rst_prev && !rst) begin
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        last_addr  = '0;
        last_wdata = '0;
        last_rdata = '0;
        rst_prev   = 1'b0;
        continue;
      end
      rst_prev = rst;
      while (gq.size() != 0 && gq[0].cyc < cyc) begin
        e = gq.pop_front();
        checks++;
        errors++;
        $display("FAIL gnt_missing: got none expected gnt %b at cycle %0d", e.oh, e.cyc);
      end
      while (rq.size() != 0 && rq[0].cyc < cyc) begin
        e = rq.pop_front();
        checks++;
        errors++;
        $display("FAIL rvalid_missing: got none expected rvalid %b at cycle %0d", e.oh, e.cyc);
      end
      if (gnt != '0 || mem_en || mem_we) begin
        if (gq.size() == 0 || gq[0].cyc != cyc) begin
          chk("gnt_unexpected", {27'b0, mem_en, gnt}, 32'd0);
        end else begin
          e = gq.pop_front();
          chk("gnt", 32'(gnt), 32'(e.oh));
          chk("mem_en", 32'(mem_en), 32'd1);
          chk("mem_we", 32'(mem_we), 32'(e.w));
          chk("mem_addr", 32'(mem_addr), 32'(e.a));
          chk("mem_wdata", mem_wdata, e.d);
          last_addr  = e.a;
          last_wdata = e.d;
        end
      end else begin
        chk("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
        chk("mem_wdata_hold", mem_wdata, last_wdata);
      end
      if (rvalid != '0) begin
        if (rq.size() == 0 || rq[0].cyc != cyc) begin
          chk("rvalid_unexpected", 32'(rvalid), 32'd0);
        end else begin
          e = rq.pop_front();
          chk("rvalid", 32'(rvalid), 32'(e.oh));
          chk("rdata", rdata, e.d);
          last_rdata = e.d;
        end
      end else begin
        chk("rdata_hold", rdata, last_rdata);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NT; i++) begin
      if (gnt[i] && !hold[i]) req[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input int t, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[t]            = 1'b1;
    we[t]             = w;
    addr[t*AW +: AW]  = a;
    wdata[t*DW +: DW] = d;
  endtask

  task automatic push_g(input int t, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int at);
    exp_t e;
    e.cyc = at; e.oh = NT'(1) << t; e.w = w; e.a = a; e.d = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input int t, input logic [DW-1:0] d, input int at);
    exp_t e;
    e.cyc = at; e.oh = NT'(1) << t; e.w = 1'b0; e.a = '0; e.d = d;
    rq.push_back(e);
  endtask

  // Called at a negedge; reset asserted mid-cycle, released on a later negedge.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : stim
    int c;
    int t;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; hold = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Tile 2 single write.
    c = cyc;
    drive(2, 1'b1, 10'h055, 32'hDEADBEEF);
    push_g(2, 1'b1, 10'h055, 32'hDEADBEEF, c + 2);
    idle(5);

    // Tile 1 writes 0x3FF, then reads it back while changing its inputs after latch.
    c = cyc;
    drive(1, 1'b1, 10'h3FF, 32'h12345678);
    push_g(1, 1'b1, 10'h3FF, 32'h12345678, c + 2);
    idle(4);
    c = cyc;
    drive(1, 1'b0, 10'h3FF, 32'h0BAD0BAD);
    push_g(1, 1'b0, 10'h3FF, 32'h0BAD0BAD, c + 2);
    push_r(1, 32'h12345678, c + 4);
    tick();
    addr[1*AW +: AW]  = 10'h000;
    wdata[1*DW +: DW] = 32'hFFFFFFFF;
    idle(6);

    // All tiles read continuously: five arbitrations, one every 3 cycles.
    req = '0;
    tick();
    pulse_reset();
    c = cyc;
    hold = '1;
    for (int i = 0; i < NT; i++) drive(i, 1'b0, 10'(16 + i), 32'h0);
    for (int k = 0; k < 5; k++) begin
`ifdef DMEM_ARBITER_RR_EN
      t = k % NT;
`else
      t = 0;
`endif
      push_g(t, 1'b0, 10'(16 + t), 32'h0, c + 2 + 3*k);
      push_r(t, 32'hC0DE0010 + 32'(t), c + 4 + 3*k);
    end
    idle(13);
    req = '0;
    hold = '0;
    idle(8);

    // Tile 3 read aborted by reset during RESP; then tiles 1 and 3 compete.
    c = cyc;
    drive(3, 1'b0, 10'h020, 32'h0);
    push_g(3, 1'b0, 10'h020, 32'h0, c + 2);
    idle(2);
    pulse_reset();
    c = cyc;
    drive(1, 1'b0, 10'h021, 32'h0);
    drive(3, 1'b0, 10'h022, 32'h0);
    push_g(1, 1'b0, 10'h021, 32'h0, c + 2);
    push_r(1, 32'hC0DE0021, c + 4);
    push_g(3, 1'b0, 10'h022, 32'h0, c + 5);
    push_r(3, 32'hC0DE0022, c + 7);
    idle(10);

    // Tile 0 drops req in ISSUE while tile 1 raises it.
    tick();
    pulse_reset();
    c = cyc;
    drive(0, 1'b0, 10'h030, 32'h0);
    push_g(0, 1'b0, 10'h030, 32'h0, c + 2);
    push_r(0, 32'hC0DE0030, c + 4);
    tick();
    req[0] = 1'b0;
    drive(1, 1'b0, 10'h031, 32'h0);
    push_g(1, 1'b0, 10'h031, 32'h0, c + 5);
    push_r(1, 32'hC0DE0031, c + 7);
    idle(9);

    // Write (2-cycle occupancy) followed by a read; then read the written word back.
    tick();
    pulse_reset();
    c = cyc;
    drive(0, 1'b1, 10'h044, 32'hA5A50F0F);
    drive(3, 1'b0, 10'h055, 32'h0);
    push_g(0, 1'b1, 10'h044, 32'hA5A50F0F, c + 2);
    push_g(3, 1'b0, 10'h055, 32'h0, c + 4);
    push_r(3, 32'hDEADBEEF, c + 6);
    idle(8);
    c = cyc;
    drive(2, 1'b0, 10'h044, 32'h0);
    push_g(2, 1'b0, 10'h044, 32'h0, c + 2);
    push_r(2, 32'hA5A50F0F, c + 4);
    idle(6);

    done = 1'b1;
    repeat (4) @(negedge clk);
    if (!mon_fin) begin
      $display("FAIL monitor_end: got unfinished expected finished");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
